// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: refresh prescaler, frame-synchronous double buffer, per-slot blanking.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading "0" glyphs at commit time.
module seg7_scan_driver #(
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7*DIGITS-1:0]   pattern_i,
    input  logic                  load_i,
    output logic [6:0]            seg_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_o,
    output logic                  updated_o
);

    localparam int W  = 7 * DIGITS;
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [PW-1:0] presc_r;
    logic [IW-1:0] idx_r;
    logic [W-1:0]  pend_r;
    logic          pend_valid_r;
    logic [W-1:0]  disp_r;
    logic          tick_s;
    logic          frame_tick_s;
    logic          commit_s;
    logic [W-1:0]  commit_data_s;
    logic [DIGITS-1:0] sel_s;
    logic [6:0]    glyph_s;
    logic [6:0]    seg_nxt_s;
    logic [DIGITS-1:0] an_nxt_s;

    // Leading "0" glyphs above digit 0 become blank; the scan stops at the first other glyph.
    function automatic logic [W-1:0] lz_blank(input logic [W-1:0] p);
`ifdef LEADING_ZERO_BLANK_EN
        logic [W-1:0] res;
        logic         run;
        res = p;
        run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (run && (p[7*k +: 7] == 7'b0000001)) begin
                res[7*k +: 7] = 7'h7F;
            end else begin
                run = 1'b0;
            end
        end
        return res;
`else
        return p;
`endif
    endfunction

    // Slot tick, frame boundary and commit selection (a load on the boundary tick wins over pending).
    always_comb begin
        tick_s        = (presc_r == PRE_LAST);
        frame_tick_s  = tick_s && (idx_r == IDX_LAST);
        commit_s      = 1'b0;
        commit_data_s = pend_r;
        if (frame_tick_s && load_i) begin
            commit_s      = 1'b1;
            commit_data_s = pattern_i;
        end else if (frame_tick_s && pend_valid_r) begin
            commit_s      = 1'b1;
            commit_data_s = pend_r;
        end else begin
            commit_s      = 1'b0;
            commit_data_s = pend_r;
        end
    end

    // Refresh prescaler and slot index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= '0;
            idx_r   <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
            idx_r   <= (idx_r == IDX_LAST) ? '0 : idx_r + 1'b1;
        end else begin
            presc_r <= presc_r + 1'b1;
        end
    end

    // Pending/display double buffer with frame-boundary commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r       <= '1;
            pend_valid_r <= 1'b0;
            disp_r       <= '1;
            frame_o      <= 1'b0;
            updated_o    <= 1'b0;
        end else begin
            frame_o   <= frame_tick_s;
            updated_o <= commit_s;
            if (load_i) begin
                pend_r <= pattern_i;
            end
            if (commit_s) begin
                disp_r       <= lz_blank(commit_data_s);
                pend_valid_r <= 1'b0;
            end else if (load_i) begin
                pend_valid_r <= 1'b1;
            end
        end
    end

    // Select the glyph of the active slot; outside the blank interval drive it with its anode.
    always_comb begin
        glyph_s = 7'h7F;
        for (int k = 0; k < DIGITS; k++) begin
            sel_s[k] = (idx_r == IW'(k));
            glyph_s  = glyph_s & (disp_r[7*k +: 7] | {7{~sel_s[k]}});
        end
        if (presc_r < BLANK_END) begin
            an_nxt_s  = '1;
            seg_nxt_s = 7'h7F;
        end else begin
            an_nxt_s  = ~sel_s;
            seg_nxt_s = glyph_s;
        end
    end

    // Registered segment and anode outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n <= 7'h7F;
            an_n  <= '1;
        end else begin
            seg_n <= seg_nxt_s;
            an_n  <= an_nxt_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (DIGITS=2, REFRESH_DIV=4, BLANK_CYC=1).
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [13:0] pattern_i;
    logic        load_i;
    logic [6:0]  seg_n;
    logic [1:0]  an_n;
    logic        frame_o;
    logic        updated_o;

    int total;
    int bad;
    int n;

    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100;
    localparam logic [6:0] G5 = 7'b0100100;
    localparam logic [6:0] G6 = 7'b0100000;
    localparam logic [6:0] G7 = 7'b0001111;
    localparam logic [6:0] BL = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LEAD0 = 7'h7F;
`else
    localparam logic [6:0] LEAD0 = 7'b0000001;
`endif

    seg7_scan_driver #(
        .DIGITS(2),
        .REFRESH_DIV(4),
        .BLANK_CYC(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pattern_i(pattern_i),
        .load_i(load_i),
        .seg_n(seg_n),
        .an_n(an_n),
        .frame_o(frame_o),
        .updated_o(updated_o)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic load(input logic [13:0] p);
        load_i    = 1'b1;
        pattern_i = p;
        @(negedge clk);
        load_i    = 1'b0;
    endtask

    task automatic wait_frame(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (frame_o !== 1'b1 && cnt < 40);
        chk("frame_seen", 32'(frame_o), 32'd1);
    endtask

    // Frame position k counts negedges after the one where frame_o was seen (k=0).
    task automatic scan_frame(input logic [6:0] t, input logic [6:0] u, input int from);
        logic [6:0] es;
        logic [1:0] ea;
        for (int k = from; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1 || k == 5) begin
                es = BL; ea = 2'b11;
            end else if (k <= 4) begin
                es = u;  ea = 2'b10;
            end else begin
                es = t;  ea = 2'b01;
            end
            chk("scan_seg", 32'(seg_n), 32'(es));
            chk("scan_an", 32'(an_n), 32'(ea));
            chk("scan_frame", 32'(frame_o), 32'd0);
            chk("scan_upd", 32'(updated_o), 32'd0);
        end
    endtask

    task automatic idle_after_reset();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("idle_frame", 32'(frame_o), (c == 8) ? 32'd1 : 32'd0);
            chk("idle_seg", 32'(seg_n), 32'(BL));
            chk("idle_upd", 32'(updated_o), 32'd0);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        clk       = 1'b0;
        rst       = 1'b0;
        load_i    = 1'b0;
        pattern_i = 14'd0;
        #1 rst = 1'b1;
        #2;
        chk("rst_seg", 32'(seg_n), 32'(BL));
        chk("rst_an", 32'(an_n), 32'd3);
        chk("rst_frame", 32'(frame_o), 32'd0);
        chk("rst_upd", 32'(updated_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_after_reset();

        // "12" becomes visible on the next frame.
        load({G1, G2});
        wait_frame(n);
        chk("load_wait", 32'(n), 32'd7);
        chk("upd_12", 32'(updated_o), 32'd1);
        chk("old_tens", 32'(seg_n), 32'(BL));
        scan_frame(G1, G2, 1);

        // Two loads in one frame: old picture stays, only the last one commits.
        wait_frame(n);
        chk("upd_none", 32'(updated_o), 32'd0);
        load({G1, G2});
        load({G6, G3});
        scan_frame(G1, G2, 3);
        wait_frame(n);
        chk("upd_63", 32'(updated_o), 32'd1);
        scan_frame(G6, G3, 1);
        wait_frame(n);
        chk("upd_once", 32'(updated_o), 32'd0);
        scan_frame(G6, G3, 1);

        // Load exactly on the boundary tick.
        load({G4, G5});
        chk("coll_frame", 32'(frame_o), 32'd1);
        chk("coll_upd", 32'(updated_o), 32'd1);
        chk("coll_old_tens", 32'(seg_n), 32'(G6));
        scan_frame(G4, G5, 1);
        wait_frame(n);
        chk("coll_no_second", 32'(updated_o), 32'd0);
        scan_frame(G4, G5, 1);

        // Exact frame period over 10 frames.
        wait_frame(n);
        for (int f = 0; f < 10; f++) begin
            wait_frame(n);
            chk("period", 32'(n), 32'd8);
        end

        // Leading-zero handling ("07", then "00" via boundary load).
        load({G0, G7});
        wait_frame(n);
        chk("upd_07", 32'(updated_o), 32'd1);
        scan_frame(LEAD0, G7, 1);
        load({G0, G0});
        chk("upd_00", 32'(updated_o), 32'd1);
        scan_frame(LEAD0, G0, 1);

        // Mid-slot reset with a pending pattern outstanding.
        wait_frame(n);
        load({G1, G2});
        @(negedge clk);
        chk("pre_rst_seg", 32'(seg_n), 32'(G0));
        chk("pre_rst_an", 32'(an_n), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_seg", 32'(seg_n), 32'(BL));
        chk("mid_rst_an", 32'(an_n), 32'd3);
        chk("mid_rst_frame", 32'(frame_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_after_reset();
        scan_frame(BL, BL, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
